// File: rtl/ubbcl_seq_subtractor_if.sv
// Operand/result handshake bundle for the sequential block-CLA subtractor.
// The producer and consumer sides drive the master modport, the subtractor uses slave.
interface ubbcl_seq_subtractor_if #(
    parameter int WIDTH = 29
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, d, borrow
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, d, borrow
    );
endinterface

// File: rtl/ubbcl_seq_subtractor.sv
// D = X - Y, one 4-bit lookahead block per cycle; 8 cycles accept-to-valid, holds in DONE while out_ready=0.
// Optional UBBCL_SUB_SAT_EN clamps d to 0 on borrow.
module ubbcl_seq_subtractor #(
    parameter int WIDTH = 29
) (
    input  logic                 clk,
    input  logic                 rst,
    ubbcl_seq_subtractor_if.slave bus
);
    localparam int BLK   = 4;
    localparam int NBLK  = (WIDTH + BLK - 1) / BLK;
    localparam int PADW  = NBLK * BLK;
    localparam int BW    = $clog2(NBLK);
    localparam int LASTW = WIDTH - (NBLK - 1) * BLK;
    localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PADW-1:0]  a_q;
    logic [PADW-1:0]  b_q;
    logic             c_q;
    logic [BW-1:0]    blk_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             out_valid_q;

    logic [BLK-1:0]   ga, gb, g, p, s;
    logic [BLK:0]     cv;
    logic             gg, pg, cout;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff;
    int               base;

    always_comb begin
        base  = int'(blk_q) * BLK;
        ga    = a_q[base +: BLK];
        gb    = b_q[base +: BLK];
        g     = ga & gb;
        p     = ga ^ gb;
        cv[0] = c_q;
        cv[1] = g[0] | (p[0] & cv[0]);
        cv[2] = g[1] | (p[1] & cv[1]);
        cv[3] = g[2] | (p[2] & cv[2]);
        gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg    = &p;
        cv[4] = gg | (pg & c_q);
        s     = p ^ cv[BLK-1:0];
        // The narrow final block takes its carry-out from inside the slice,
        // since the zero padding above it would kill the group generate.
        cout  = (blk_q == LAST_BLK) ? cv[LASTW] : cv[BLK];

        res_nxt = res_q;
        for (int i = 0; i < BLK; i++) begin
            if (base + i < WIDTH) res_nxt[base + i] = s[i];
        end

        diff = res_nxt;
`ifdef UBBCL_SUB_SAT_EN
        if (!cout) diff = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            blk_q       <= '0;
            res_q       <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= {{(PADW-WIDTH){1'b0}}, bus.x};
                        b_q   <= {{(PADW-WIDTH){1'b0}}, ~bus.y};
                        c_q   <= 1'b1;
                        blk_q <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_nxt;
                    c_q   <= cout;
                    blk_q <= blk_q + BW'(1);
                    if (blk_q == LAST_BLK) begin
                        d_q         <= diff;
                        borrow_q    <= ~cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_ubbcl_seq_subtractor.sv
// Scoreboard bench for ubbcl_seq_subtractor: directed corner cases, backpressure, mid-op reset, random stalls.
module tb_ubbcl_seq_subtractor;
    localparam int W = 29;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ubbcl_seq_subtractor_if #(.WIDTH(W)) bus ();
    ubbcl_seq_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.b = (y > x);
        e.d = (x - y) & MASK;
`ifdef UBBCL_SUB_SAT_EN
        if (e.b) e.d = '0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand pair until accepted; push its expected result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = x;
        bus.y = y;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.x = $urandom;
        bus.y = $urandom;
        if (ok) sb.push_back(model(x, y));
    endtask

    // Wait for a result handshake; lat counts edges until out_valid was seen.
    task automatic collect(input bit stall, output exp_t got, output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        got = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #0;
            if (bus.out_valid && bus.out_ready) begin
                got.d = bus.d;
                got.b = bus.borrow;
                ok = 1'b1;
            end else if (!bus.out_valid) begin
                lat++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_pop(input string name, input exp_t got);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: result d=%h b=%0d with empty scoreboard", name, got.d, got.b);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got d=%h borrow=%0d, expected d=%h borrow=%0d", name, got.d, got.b, e.d, e.b);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.d !== '0 || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b d=%h borrow=%b, expected 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.d, bus.borrow);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        exp_t got;
        int lat;
        bit ok;
        send(29'd100, 29'd58, ok);
        collect(1'b0, got, lat, ok);
        n_cmp++;
        if (!ok || lat !== 8) begin
            n_err++;
            $display("FAIL basic_latency: ok=%0d latency=%0d expected 8", ok, lat);
        end
        if (ok) check_pop("basic_100_58", got);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid_pulse: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_corner();
        logic [W-1:0] xs[4] = '{29'd0, 29'h1000_0000, 29'h1FFF_FFFF, 29'h0ABC_DEF0};
        logic [W-1:0] ys[4] = '{29'd1, 29'd1,         29'h1FFF_FFFF, 29'h1ABC_DEF0};
        exp_t got;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], ys[i], ok);
            collect(1'b0, got, lat, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL corner_timeout: case %0d produced no result", i);
                void'(sb.pop_front());
            end else check_pop($sformatf("corner_%0d", i), got);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, held;
        int lat;
        bit ok, bad;
        send(29'd500, 29'd20, ok);
        collect(1'b0, got, lat, ok);
        check_pop("b2b_first", got);
        send(29'd30, 29'd500, ok);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        held.d = bus.d;
        held.b = bus.borrow;
        bus.in_valid = 1'b1;
        bus.x = 29'd1000;
        bus.y = 29'd1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.d !== held.d || bus.borrow !== held.b || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL backpressure_hold: d=%h borrow=%b in_ready=%b out_valid=%b", bus.d, bus.borrow, bus.in_ready, bus.out_valid);
        end
        check_pop("backpressure_result", held);
        bus.out_ready = 1'b1;
        #0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL release_no_accept: in_ready=%b expected 0 during handshake", bus.in_ready);
        end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_idle: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        sb.push_back(model(29'd1000, 29'd1));
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pending_accept: in_ready=%b expected 0 after accept", bus.in_ready);
        end
        collect(1'b0, got, lat, ok);
        n_cmp++;
        if (!ok || lat !== 8) begin
            n_err++;
            $display("FAIL pending_latency: ok=%0d latency=%0d expected 8", ok, lat);
        end
        if (ok) check_pop("pending_result", got);
    endtask

    task automatic test_reset_mid();
        exp_t got;
        int lat;
        bit ok;
        send(29'd12345, 29'd678, ok);
        void'(sb.pop_back());
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.d !== '0 || bus.borrow !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b d=%h borrow=%b in_ready=%b expected 0 0 0 0",
                     bus.out_valid, bus.d, bus.borrow, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_release: in_ready=%b expected 1", bus.in_ready);
        end
        send(29'd7, 29'd9, ok);
        collect(1'b0, got, lat, ok);
        n_cmp++;
        if (!ok || lat !== 8) begin
            n_err++;
            $display("FAIL after_reset_latency: ok=%0d latency=%0d expected 8", ok, lat);
        end
        if (ok) check_pop("after_reset_7_9", got);
    endtask

    task automatic test_random();
        exp_t got;
        int lat;
        bit ok;
        logic [W-1:0] x, y;
        for (int i = 0; i < 2000; i++) begin
            x = $urandom & MASK;
            y = $urandom & MASK;
            case ($urandom_range(0, 5))
                0: y = x;
                1: y = x + 1;
                2: x = '1;
                default: ;
            endcase
            send(x, y, ok);
            collect(1'b1, got, lat, ok);
            if (!ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL random_timeout: iteration %0d", i);
                void'(sb.pop_front());
            end else check_pop("random", got);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        #12;
        test_reset();
        test_basic();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
